// File: rtl/tone_mixer.sv
// tone_mixer: multi-voice square-wave tone generator mixed with passthrough audio,
// with per-voice durations counted in transferred samples and saturating output.
module tone_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SEL_WIDTH = 2,
  parameter int DIV_WIDTH = 19,
  parameter int DUR_WIDTH = 16,
  parameter int SAMPLE_WIDTH = 32,
  parameter logic [31:0] AMPLITUDE = 32'h03FFFFFC
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    voice_load,
  input  logic [SEL_WIDTH-1:0]    voice_sel,
  input  logic [DIV_WIDTH-1:0]    voice_half_period,
  input  logic [DUR_WIDTH-1:0]    voice_duration,
  input  logic                    passthrough_en,
  input  logic                    audio_in_available,
  input  logic                    audio_out_allowed,
  input  logic [SAMPLE_WIDTH-1:0] left_channel_audio_in,
  input  logic [SAMPLE_WIDTH-1:0] right_channel_audio_in,
  output logic                    read_audio_in,
  output logic                    write_audio_out,
  output logic [SAMPLE_WIDTH-1:0] left_channel_audio_out,
  output logic [SAMPLE_WIDTH-1:0] right_channel_audio_out,
  output logic [NUM_VOICES-1:0]   voice_active
);
  localparam int MW = SAMPLE_WIDTH + 4;
  localparam logic signed [MW-1:0] AMP = MW'(AMPLITUDE);
  logic xfer;
  logic [NUM_VOICES-1:0] act, ph;
  logic signed [MW-1:0] mix_d, mix_q;
  assign xfer = audio_in_available & audio_out_allowed & ~reset;
  assign read_audio_in = xfer;
  assign write_audio_out = xfer;
  assign voice_active = act;
  genvar v;
  for (v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic active_d, active_q, phase_d, phase_q, ld, wrap;
    logic [DIV_WIDTH-1:0] cnt_d, cnt_q, per_d, per_q;
    logic [DUR_WIDTH-1:0] rem_d, rem_q;
    assign ld = voice_load & (voice_sel == SEL_WIDTH'(v));
    assign wrap = cnt_q == per_q;
    always_comb begin
      active_d = active_q;
      phase_d = phase_q;
      cnt_d = cnt_q;
      per_d = per_q;
      rem_d = rem_q;
      if (ld) begin
        per_d = voice_half_period;
        cnt_d = '0;
        phase_d = 1'b0;
        rem_d = voice_duration;
        active_d = |voice_duration;
      end else if (active_q) begin
        cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
        phase_d = phase_q ^ wrap;
        rem_d = (xfer && rem_q != '1) ? rem_q - DUR_WIDTH'(1) : rem_q;
        if (xfer && rem_q == DUR_WIDTH'(1)) begin
          active_d = 1'b0;
          phase_d = 1'b0;
          cnt_d = '0;
        end
      end
    end
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        active_q <= 1'b0;
        phase_q <= 1'b0;
        cnt_q <= '0;
        per_q <= '0;
        rem_q <= '0;
      end else begin
        active_q <= active_d;
        phase_q <= phase_d;
        cnt_q <= cnt_d;
        per_q <= per_d;
        rem_q <= rem_d;
      end
    end
    assign act[v] = active_q;
    assign ph[v] = phase_q;
  end
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      mix_d = mix_d + (act[i] ? (ph[i] ? AMP : -AMP) : '0);
  end
  always_ff @(posedge CLOCK_50) mix_q <= reset ? '0 : mix_d;
  // Headroom bits all equal the sign means the sum fits in SAMPLE_WIDTH.
  function automatic logic [SAMPLE_WIDTH-1:0] sat_mix(input logic pass, input logic [SAMPLE_WIDTH-1:0] din,
                                                      input logic signed [MW-1:0] mix);
    logic [MW-1:0] s;
    s = (pass ? {{4{din[SAMPLE_WIDTH-1]}}, din} : '0) + mix;
    return (s[MW-1:SAMPLE_WIDTH-1] == '0 || s[MW-1:SAMPLE_WIDTH-1] == '1) ? s[SAMPLE_WIDTH-1:0]
           : {s[MW-1], {(SAMPLE_WIDTH-1){~s[MW-1]}}};
  endfunction
  assign left_channel_audio_out = sat_mix(passthrough_en, left_channel_audio_in, mix_q);
  assign right_channel_audio_out = sat_mix(passthrough_en, right_channel_audio_in, mix_q);
endmodule

// File: tb/tb_tone_mixer.sv
// tb_tone_mixer: randomized scoreboard bench; a timeline model of each voice predicts
// every cycle's handshake, voice_active and saturated mixed samples.
module tb_tone_mixer;
  localparam int NV = 3;
  localparam longint A = 64'h03FFFFFC;
  logic CLOCK_50, reset, voice_load, passthrough_en, audio_in_available, audio_out_allowed;
  logic [1:0] voice_sel;
  logic [18:0] voice_half_period;
  logic [15:0] voice_duration;
  logic [31:0] left_channel_audio_in, right_channel_audio_in, left_channel_audio_out, right_channel_audio_out;
  logic read_audio_in, write_audio_out;
  logic [NV-1:0] voice_active;
  tone_mixer #(.NUM_VOICES(NV), .SEL_WIDTH(2), .DIV_WIDTH(19), .DUR_WIDTH(16), .SAMPLE_WIDTH(32),
               .AMPLITUDE(32'h03FFFFFC)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .voice_load(voice_load), .voice_sel(voice_sel),
    .voice_half_period(voice_half_period), .voice_duration(voice_duration),
    .passthrough_en(passthrough_en), .audio_in_available(audio_in_available),
    .audio_out_allowed(audio_out_allowed), .left_channel_audio_in(left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in), .read_audio_in(read_audio_in),
    .write_audio_out(write_audio_out), .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out), .voice_active(voice_active));
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;
  typedef struct {
    bit x;
    logic [31:0] l, r;
    logic [NV-1:0] va;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  bit m_act[NV];
  longint m_k[NV];
  int m_hp[NV], m_dur[NV], m_x[NV];
  longint cyc = 0, m_mix = 0;
  // A voice's phase is the parity of whole half-periods elapsed since its load edge.
  function automatic longint contrib(int v, longint t);
    if (!m_act[v]) return 0;
    return (((t - m_k[v]) / (m_hp[v] + 1)) % 2) != 0 ? A : -A;
  endfunction
  function automatic logic [31:0] sat_ref(logic [31:0] din, bit pass, longint mix);
    longint s;
    s = (pass ? longint'($signed(din)) : 0) + mix;
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction
  task automatic step(input bit ld, input int sel, input int hp, input int dur, input bit pass,
                      input bit av, input bit al, input bit rst, input logic [31:0] l, input logic [31:0] r);
    longint mx;
    bit xf;
    exp_t e;
    @(posedge CLOCK_50);
    cyc++;
    mx = 0;
    for (int v = 0; v < NV; v++) mx += contrib(v, cyc - 1);
    m_mix = reset ? 0 : mx;
    xf = audio_in_available && audio_out_allowed && !reset;
    for (int v = 0; v < NV; v++) begin
      if (reset) m_act[v] = 0;
      else if (voice_load && int'(voice_sel) == v) begin
        m_act[v] = voice_duration != 0;
        m_k[v] = cyc;
        m_hp[v] = int'(voice_half_period);
        m_dur[v] = int'(voice_duration);
        m_x[v] = 0;
      end else if (m_act[v] && xf && m_dur[v] != 16'hFFFF) begin
        m_x[v]++;
        if (m_x[v] == m_dur[v]) m_act[v] = 0;
      end
    end
    #1;
    voice_load = ld;
    voice_sel = 2'(sel);
    voice_half_period = 19'(hp);
    voice_duration = 16'(dur);
    passthrough_en = pass;
    audio_in_available = av;
    audio_out_allowed = al;
    reset = rst;
    left_channel_audio_in = l;
    right_channel_audio_in = r;
    e.x = av && al && !rst;
    e.l = sat_ref(l, pass, m_mix);
    e.r = sat_ref(r, pass, m_mix);
    for (int v = 0; v < NV; v++) e.va[v] = m_act[v];
    sb.push_back(e);
  endtask
  task automatic idle(input int n, input bit pass, input bit av, input bit al, input logic [31:0] l, input logic [31:0] r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, pass, av, al, 0, l, r);
  endtask
  initial begin
    exp_t e;
    @(posedge CLOCK_50);
    forever begin
      @(negedge CLOCK_50);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: no expected entry at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        n_chk++;
        if (read_audio_in !== e.x || write_audio_out !== e.x) begin
          n_fail++;
          $display("FAIL handshake cyc %0d: read=%b write=%b required %b", cyc, read_audio_in, write_audio_out, e.x);
        end
        n_chk++;
        if (voice_active !== e.va) begin
          n_fail++;
          $display("FAIL voice_active cyc %0d: got %b required %b", cyc, voice_active, e.va);
        end
        if (write_audio_out && e.x) begin
          n_chk++;
          if (left_channel_audio_out !== e.l) begin
            n_fail++;
            $display("FAIL left_out cyc %0d: got %h required %h", cyc, left_channel_audio_out, e.l);
          end
          n_chk++;
          if (right_channel_audio_out !== e.r) begin
            n_fail++;
            $display("FAIL right_out cyc %0d: got %h required %h", cyc, right_channel_audio_out, e.r);
          end
        end
      end
    end
  end
  initial begin
    int dsel;
    logic [31:0] l, r;
    reset = 1; voice_load = 0; voice_sel = 0; voice_half_period = 0; voice_duration = 0;
    passthrough_en = 0; audio_in_available = 0; audio_out_allowed = 0;
    left_channel_audio_in = 0; right_channel_audio_in = 0;
    for (int i = 0; i < NV; i++) m_act[i] = 0;
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(1, 0, 3, 16'hFFFF, 0, 1, 1, 0, 0, 0);
    idle(20, 0, 1, 1, 32'h12345678, 32'h9ABCDEF0);
    step(1, 1, 1, 3, 0, 1, 1, 0, 0, 0);
    idle(8, 0, 1, 1, 0, 0);
    idle(10, 1, 1, 1, 32'h7FFFFFF0, 32'h80000010);
    step(1, 2, 2, 1, 0, 1, 1, 0, 0, 0);
    step(1, 2, 2, 5, 0, 1, 1, 0, 0, 0);
    idle(8, 0, 1, 1, 0, 0);
    step(1, 1, 0, 4, 1, 1, 0, 0, 32'h11111111, 32'h22222222);
    idle(6, 1, 1, 0, 32'h11111111, 32'h22222222);
    idle(6, 1, 1, 1, 32'h11111111, 32'h22222222);
    step(0, 0, 0, 0, 1, 1, 1, 1, 32'h0BADF00D, 32'hDEADBEEF);
    idle(3, 1, 1, 1, 32'h0BADF00D, 32'hDEADBEEF);
    step(1, 0, 2, 16'hFFFF, 0, 1, 1, 0, 0, 0);
    step(1, 3, 1, 5, 0, 1, 1, 0, 0, 0);
    idle(6, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: dsel = 0;
        1: dsel = 16'hFFFF;
        default: dsel = int'($urandom_range(1, 12));
      endcase
      case ($urandom_range(0, 3))
        0: begin l = 32'h7FFFFFF0; r = 32'h80000010; end
        1: begin l = 32'h80000010; r = 32'h7FFFFFF0; end
        default: begin l = $urandom; r = $urandom; end
      endcase
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 40)), dsel,
           $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) == 0, l, r);
    end
    @(negedge CLOCK_50);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_mixer.md
Name: tone_mixer

Overview:
- Multi-voice square-wave tone generator. Mixes its tones with the passthrough microphone/line-in audio.
- Sits between the board audio controller's sample FIFO interface and the user controls.
- Successor to the single-tone switch-driven generator, with these additions:
  - NUM_VOICES independently loaded voices.
  - Per-voice note duration, counted in samples.
  - Registered mixing.
  - Saturating output arithmetic instead of wrap-around.

Parameters:
- NUM_VOICES, 4, number of independent tone voices (1..8).
- SEL_WIDTH, 2, width of voice_sel; must satisfy 2^SEL_WIDTH >= NUM_VOICES.
- DIV_WIDTH, 19, width of the half-period divider (CLOCK_50 cycles).
- DUR_WIDTH, 16, width of the note duration counter (samples).
- SAMPLE_WIDTH, 32, signed audio sample width.
- AMPLITUDE, 32'h03FFFFFC, per-voice square amplitude (positive; fits in SAMPLE_WIDTH).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- voice_load  in  1  one-cycle strobe; loads voice_sel with period and duration.
- voice_sel  in  SEL_WIDTH  target voice index.
- voice_half_period  in  DIV_WIDTH  toggle threshold; tone period = 2*(value+1) clocks.
- voice_duration  in  DUR_WIDTH  note length in samples:
  - 0 = stop voice.
  - all-ones = sustain forever.
- passthrough_en  in  1  1 = add input audio to the output; 0 = tones only.
- audio_in_available  in  1  controller has an input sample.
- audio_out_allowed  in  1  controller can accept an output sample.
- left_channel_audio_in  in  SAMPLE_WIDTH  signed input sample.
- right_channel_audio_in  in  SAMPLE_WIDTH  signed input sample.
- read_audio_in  out  1  pops the input sample.
- write_audio_out  out  1  pushes the output sample.
- left_channel_audio_out  out  SAMPLE_WIDTH  signed mixed sample.
- right_channel_audio_out  out  SAMPLE_WIDTH  signed mixed sample.
- voice_active  out  NUM_VOICES  bit i = voice i currently sounding.

Behaviour:
- Reset (synchronous, on CLOCK_50 edge with reset=1):
  - Clears all voice state: active, phase, divider count, period, remaining.
  - Clears mix_reg.
  - voice_active=0.
  - read_audio_in and write_audio_out are forced 0 while reset is high.
  - Reset mid-note silences that voice on the next cycle. It does not resume after reset.
- Transfer (xfer):
  - xfer = audio_in_available & audio_out_allowed & ~reset.
  - read_audio_in = write_audio_out = xfer (combinational, same cycle).
  - The input FIFO is drained even when passthrough_en=0.
- Voice divider (each active voice, every clock):
  - If cnt == period: cnt <= 0 and phase toggles.
  - Otherwise cnt <= cnt+1.
  - period=0 toggles every clock.
  - Inactive voices hold cnt=0 and phase=0.
- Load:
  - On voice_load with voice_sel < NUM_VOICES:
    - period <= voice_half_period, cnt <= 0, phase <= 0.
    - remaining <= voice_duration.
    - active <= (voice_duration != 0).
  - voice_sel >= NUM_VOICES: ignored, no state change.
  - Reloading a sounding voice restarts it immediately.
- Duration (on each xfer cycle, per active voice):
  - If remaining != all-ones: remaining decrements.
  - When remaining goes 1 -> 0: active <= 0, phase <= 0, cnt <= 0.
  - A load on the same cycle as a decrement of the same voice: load wins.
  - Loads to other voices are independent.
- Mix:
  - mix_reg is registered and updated every clock.
  - mix_reg = signed sum over voices of contribution(i):
    - active & phase = +AMPLITUDE.
    - active & ~phase = -AMPLITUDE.
    - inactive = 0.
  - Width is SAMPLE_WIDTH+4 bits, so no overflow is possible.
  - Latency: one clock from a phase/active change to mix_reg.
- Output (combinational from current inputs and mix_reg):
  - out = sat(src + mix_reg), where src = channel_in if passthrough_en, else 0.
  - The addition is sign-extended to SAMPLE_WIDTH+4 bits.
  - sat clamps to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Left and right use the same mix_reg.
- voice_active is a direct registered view of the active bits; it is valid the cycle after the load or expiry.

Test Plan:
- Single voice: reset, then load voice 0 with hp=3, dur=all-ones, passthrough_en=0. Required:
  - phase toggles every 4 clocks.
  - outputs alternate 32'h03FFFFFC / 32'hFC000004 (−AMPLITUDE) in 4-clock runs.
  - voice_active=4'b0001.
- Duration: load voice 1 with dur=3, hold xfer=1 continuously. Required:
  - voice_active[1] falls exactly 3 clocks after the load takes effect.
  - its contribution is 0 from the following clock.
- Positive saturation:
  - Setup: passthrough_en=1, left_in=32'h7FFFFFF0, all 4 voices in phase=1.
  - left_out = 32'h7FFFFFFF.
  - Repeat with right_in=32'h80000010 and all voices at phase=0: right_out = 32'h80000000.
- Load/decrement collision: voice 2 has remaining=1, and a voice_load to voice 2 (dur=5) arrives on an xfer cycle. Required: voice stays active with remaining=5, cnt=0.
- Handshake and reset:
  - audio_out_allowed=0: read_audio_in=write_audio_out=0 and remaining does not change.
  - Assert reset mid-note: next clock voice_active=0, mix_reg=0, outputs equal the input samples (passthrough on).
- Invalid select: NUM_VOICES=3, load voice_sel=3. Required: no voice_active change, output unchanged.
